// File: rtl/frame_dma_sequencer_pkg.sv
// Shared types and constants for the frame DMA sequencer: FSM state encoding
// and line-buffer geometry.
package camerica_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_LINE,
    READ,
    WRITE,
    FRAME_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int BUF_WORDS      = 512;
  localparam int WORD_AW        = $clog2(BUF_WORDS);

endpackage

// File: rtl/frame_dma_sequencer_if.sv
// Bus bundle for the sequencer: line-memory read port plus the Avalon-MM
// write master into HPS SDRAM.
interface frame_dma_sequencer_if;
  import camerica_pkg::*;

  logic               vm_bus_enable;
  logic               vm_rw;
  logic [WORD_AW:0]   vm_address;
  logic               vm_acknowledge;
  logic [63:0]        vm_read_data;

  logic [31:0]        m_address;
  logic               m_write;
  logic [63:0]        m_writedata;
  logic               m_waitrequest;

  modport master (
    output vm_bus_enable, vm_rw, vm_address, m_address, m_write, m_writedata,
    input  vm_acknowledge, vm_read_data, m_waitrequest
  );

  modport slave (
    input  vm_bus_enable, vm_rw, vm_address, m_address, m_write, m_writedata,
    output vm_acknowledge, vm_read_data, m_waitrequest
  );

endinterface

// File: rtl/frame_dma_sequencer_edge_detect.sv
// Registered edge detector: samples the input once and flags either any
// toggle or only a rising edge. The first clock after reset primes the
// history so a static level never reads as an edge.
module edge_detect #(
  parameter bit RISE_ONLY = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic hit
);

  logic hist;
  logic primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= 1'b0;
      hist   <= 1'b0;
      primed <= 1'b0;
    end else if (!primed) begin
      q      <= d;
      hist   <= d;
      primed <= 1'b1;
    end else begin
      q      <= d;
      hist   <= q;
    end
  end

  assign hit = RISE_ONLY ? (q & ~hist) : (q ^ hist);

endmodule

// File: rtl/frame_dma_sequencer.sv
// Drains each completed line from the double-buffered line memory into HPS
// SDRAM at a running address, counts frames and flags overruns/short frames.
module frame_dma_sequencer
  import camerica_pkg::*;
#(
  parameter int LINE_WORDS  = 160,
  parameter int FRAME_LINES = 480
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dma_enable,
  input  logic [31:0]                 dma_base,
  input  logic                        which_line,
  input  logic                        vid_vblank,
  input  logic                        err_clear,
  frame_dma_sequencer_if.master       bus,
  output logic                        dma_active,
  output logic [31:0]                 frame_counter,
  output logic                        new_frame,
  output logic                        err_overrun,
  output logic                        err_short
);

  localparam logic [WORD_AW:0]   LAST_WORD = (WORD_AW + 1)'(LINE_WORDS);
  localparam logic [10:0]        LAST_LINE = 11'(FRAME_LINES);
  localparam logic [31:0]        PTR_STEP  = 32'(BYTES_PER_WORD);

  state_t               state;
  logic [31:0]          pointer;
  logic [WORD_AW-1:0]   word;
  logic [9:0]           line_cnt;
  logic                 drain_buf;
  logic                 quit_idle;
  logic                 quit_sync;

  logic                 wl_level;
  logic                 wl_tgl;
  logic                 vb_level_unused;
  logic                 vb_rise;

  logic [WORD_AW:0]     word_nxt;
  logic [10:0]          line_nxt;

  edge_detect #(.RISE_ONLY(1'b0)) u_line_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (which_line),
    .q     (wl_level),
    .hit   (wl_tgl)
  );

  edge_detect #(.RISE_ONLY(1'b1)) u_vblank_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vid_vblank),
    .q     (vb_level_unused),
    .hit   (vb_rise)
  );

  assign word_nxt  = {1'b0, word} + 1'b1;
  assign line_nxt  = {1'b0, line_cnt} + 11'd1;
  assign bus.vm_rw = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      pointer           <= '0;
      word              <= '0;
      line_cnt          <= '0;
      drain_buf         <= 1'b0;
      quit_idle         <= 1'b0;
      quit_sync         <= 1'b0;
      bus.vm_bus_enable <= 1'b0;
      bus.vm_address    <= '0;
      bus.m_address     <= '0;
      bus.m_write       <= 1'b0;
      bus.m_writedata   <= '0;
      dma_active        <= 1'b0;
      frame_counter     <= '0;
      new_frame         <= 1'b0;
      err_overrun       <= 1'b0;
      err_short         <= 1'b0;
    end else begin
      new_frame <= 1'b0;
      // A clear in the same cycle as a new error loses: error sets come later.
      if (err_clear) begin
        err_overrun <= 1'b0;
        err_short   <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (dma_enable) begin
            state      <= SYNC;
            dma_active <= 1'b1;
          end
        end

        SYNC: begin
          if (!dma_enable) begin
            state      <= IDLE;
            dma_active <= 1'b0;
          end else if (vb_rise) begin
            pointer  <= dma_base;
            line_cnt <= '0;
            state    <= WAIT_LINE;
          end
        end

        WAIT_LINE: begin
          if (!dma_enable) begin
            state      <= IDLE;
            dma_active <= 1'b0;
          end else begin
            if (vb_rise) begin
              if ({1'b0, line_cnt} < LAST_LINE) err_short <= 1'b1;
              pointer  <= dma_base;
              line_cnt <= '0;
            end
            // The reader has just switched to the other buffer; drain the one it left.
            if (wl_tgl) begin
              drain_buf         <= ~wl_level;
              word              <= '0;
              bus.vm_bus_enable <= 1'b1;
              bus.vm_address    <= {~wl_level, {WORD_AW{1'b0}}};
              state             <= READ;
            end
          end
        end

        READ: begin
          if (!dma_enable) begin
            bus.vm_bus_enable <= 1'b0;
            state             <= IDLE;
            dma_active        <= 1'b0;
          end else if (wl_tgl) begin
            err_overrun       <= 1'b1;
            bus.vm_bus_enable <= 1'b0;
            state             <= SYNC;
          end else if (bus.vm_acknowledge) begin
            bus.vm_bus_enable <= 1'b0;
            bus.m_write       <= 1'b1;
            bus.m_address     <= pointer;
            bus.m_writedata   <= bus.vm_read_data;
            state             <= WRITE;
          end
        end

        WRITE: begin
          // Aborts are remembered so the in-flight Avalon write always completes.
          if (wl_tgl) begin
            err_overrun <= 1'b1;
            quit_sync   <= 1'b1;
          end
          if (!dma_enable) quit_idle <= 1'b1;

          if (!bus.m_waitrequest) begin
            bus.m_write <= 1'b0;
            pointer     <= pointer + PTR_STEP;
            word        <= word + 1'b1;
            quit_idle   <= 1'b0;
            quit_sync   <= 1'b0;
            if (quit_idle || !dma_enable) begin
              state      <= IDLE;
              dma_active <= 1'b0;
            end else if (quit_sync || wl_tgl) begin
              state <= SYNC;
            end else if (word_nxt == LAST_WORD) begin
              line_cnt <= line_nxt[9:0];
              if (line_nxt == LAST_LINE) begin
                state         <= FRAME_DONE;
                new_frame     <= 1'b1;
                frame_counter <= frame_counter + 32'd1;
              end else begin
                state <= WAIT_LINE;
              end
            end else begin
              bus.vm_bus_enable <= 1'b1;
              bus.vm_address    <= {drain_buf, word_nxt[WORD_AW-1:0]};
              state             <= READ;
            end
          end
        end

        FRAME_DONE: begin
          state <= SYNC;
        end

        default: begin
          state      <= IDLE;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_dma_sequencer.sv
// Directed bench for frame_dma_sequencer with a small line memory and a
// stallable Avalon slave model; LINE_WORDS=4, FRAME_LINES=2.
module tb_frame_dma_sequencer;

  localparam int LW = 4;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_enable = 1'b0;
  logic [31:0] dma_base = 32'h0;
  logic        which_line = 1'b0;
  logic        vid_vblank = 1'b0;
  logic        err_clear = 1'b0;
  logic        dma_active;
  logic [31:0] frame_counter;
  logic        new_frame;
  logic        err_overrun;
  logic        err_short;

  frame_dma_sequencer_if bus();

  frame_dma_sequencer #(.LINE_WORDS(LW), .FRAME_LINES(FL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dma_enable    (dma_enable),
    .dma_base      (dma_base),
    .which_line    (which_line),
    .vid_vblank    (vid_vblank),
    .err_clear     (err_clear),
    .bus           (bus),
    .dma_active    (dma_active),
    .frame_counter (frame_counter),
    .new_frame     (new_frame),
    .err_overrun   (err_overrun),
    .err_short     (err_short)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int wait_n = 0;
  int stall_cnt = 0;
  int stall_total = 0;
  int nf_cnt = 0;
  int unstable = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  logic [63:0] hold_data = 64'h0;
  logic [31:0] wr_addr[$];
  logic [63:0] wr_data[$];

  // Line memory answers in the same cycle; data encodes the address it came from.
  assign bus.vm_acknowledge = bus.vm_bus_enable;
  assign bus.vm_read_data   = {16'hA5A5, 6'd0, bus.vm_address, 22'd0, bus.vm_address};
  assign bus.m_waitrequest  = bus.m_write && (stall_cnt < wait_n);

  always @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      stall_cnt  <= 0;
    end else begin
      if (new_frame) nf_cnt <= nf_cnt + 1;
      if (hold_valid && (!bus.m_write || bus.m_address !== hold_addr || bus.m_writedata !== hold_data))
        unstable <= unstable + 1;
      if (bus.m_write && bus.m_waitrequest) begin
        hold_valid  <= 1'b1;
        hold_addr   <= bus.m_address;
        hold_data   <= bus.m_writedata;
        stall_cnt   <= stall_cnt + 1;
        stall_total <= stall_total + 1;
      end else begin
        hold_valid <= 1'b0;
      end
      if (bus.m_write && !bus.m_waitrequest) begin
        wr_addr.push_back(bus.m_address);
        wr_data.push_back(bus.m_writedata);
        stall_cnt <= 0;
      end
    end
  end

  function automatic logic [63:0] exp_data(input logic b, input int w);
    logic [9:0] a;
    a = {b, 9'(w)};
    return {16'hA5A5, 6'd0, a, 22'd0, a};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vblank_pulse();
    vid_vblank = 1'b1;
    tick(3);
    vid_vblank = 1'b0;
    tick(3);
  endtask

  task automatic toggle_line();
    which_line = ~which_line;
    tick(1);
  endtask

  task automatic wait_writes(input int n, input int budget, output bit timed_out);
    int c;
    c = 0;
    while (wr_addr.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    timed_out = (wr_addr.size() < n);
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if (bus.m_write !== 1'b0) begin n_fail++; $display("FAIL reset_m_write: got %b want 0", bus.m_write); end
    n_cmp++; if (bus.vm_bus_enable !== 1'b0) begin n_fail++; $display("FAIL reset_vm_en: got %b want 0", bus.vm_bus_enable); end
    n_cmp++; if (bus.vm_rw !== 1'b1) begin n_fail++; $display("FAIL reset_vm_rw: got %b want 1", bus.vm_rw); end
    n_cmp++; if (frame_counter !== 32'd0) begin n_fail++; $display("FAIL reset_frame_counter: got %0d want 0", frame_counter); end
    rst_n = 1'b1;
    tick(3);
    n_cmp++; if (dma_active !== 1'b0) begin n_fail++; $display("FAIL reset_idle_active: got %b want 0", dma_active); end
    n_cmp++; if ({err_overrun, err_short, new_frame} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {err_overrun, err_short, new_frame}); end
  endtask

  task automatic test_frame();
    int b, n0;
    bit to;
    b = wr_addr.size(); n0 = nf_cnt;
    wait_n = 0; dma_base = 32'h1000; dma_enable = 1'b1;
    tick(3);
    n_cmp++; if (dma_active !== 1'b1) begin n_fail++; $display("FAIL frame_active: got %b want 1", dma_active); end
    vblank_pulse();
    toggle_line();
    wait_writes(b + 4, 100, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL frame_line0_timeout: got %0d writes want %0d", wr_addr.size() - b, 4); end
    toggle_line();
    wait_writes(b + 8, 100, to);
    tick(5);
    n_cmp++; if (wr_addr.size() !== b + 8) begin n_fail++; $display("FAIL frame_count: got %0d writes want 8", wr_addr.size() - b); end
    for (int i = 0; i < 8 && b + i < wr_addr.size(); i++) begin
      n_cmp++; if (wr_addr[b+i] !== 32'h1000 + 32'(8*i)) begin n_fail++; $display("FAIL frame_addr[%0d]: got %h want %h", i, wr_addr[b+i], 32'h1000 + 32'(8*i)); end
      n_cmp++; if (wr_data[b+i] !== exp_data(i >= 4, i % 4)) begin n_fail++; $display("FAIL frame_data[%0d]: got %h want %h", i, wr_data[b+i], exp_data(i >= 4, i % 4)); end
    end
    n_cmp++; if (nf_cnt - n0 !== 1) begin n_fail++; $display("FAIL frame_new_frame: got %0d pulses want 1", nf_cnt - n0); end
    n_cmp++; if (frame_counter !== 32'd1) begin n_fail++; $display("FAIL frame_counter: got %0d want 1", frame_counter); end
  endtask

  task automatic test_stall();
    int b, n0, u0, s0;
    bit to;
    b = wr_addr.size(); n0 = nf_cnt; u0 = unstable; s0 = stall_total;
    wait_n = 3; dma_base = 32'h1000;
    vblank_pulse();
    toggle_line();
    wait_writes(b + 4, 200, to);
    toggle_line();
    wait_writes(b + 8, 200, to);
    tick(5);
    n_cmp++; if (wr_addr.size() !== b + 8) begin n_fail++; $display("FAIL stall_count: got %0d writes want 8", wr_addr.size() - b); end
    for (int i = 0; i < 8 && b + i < wr_addr.size(); i++) begin
      n_cmp++; if (wr_addr[b+i] !== 32'h1000 + 32'(8*i)) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want %h", i, wr_addr[b+i], 32'h1000 + 32'(8*i)); end
      n_cmp++; if (wr_data[b+i] !== exp_data(i >= 4, i % 4)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, wr_data[b+i], exp_data(i >= 4, i % 4)); end
    end
    n_cmp++; if (stall_total - s0 !== 24) begin n_fail++; $display("FAIL stall_cycles: got %0d want 24", stall_total - s0); end
    n_cmp++; if (unstable - u0 !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", unstable - u0); end
    n_cmp++; if (nf_cnt - n0 !== 1) begin n_fail++; $display("FAIL stall_new_frame: got %0d want 1", nf_cnt - n0); end
    n_cmp++; if (frame_counter !== 32'd2) begin n_fail++; $display("FAIL stall_frame_counter: got %0d want 2", frame_counter); end
  endtask

  task automatic test_overrun();
    int b, n0;
    bit to;
    b = wr_addr.size(); n0 = nf_cnt;
    wait_n = 3; dma_base = 32'h1000;
    vblank_pulse();
    toggle_line();
    wait_writes(b + 2, 100, to);
    toggle_line();
    wait_writes(b + 3, 100, to);
    tick(20);
    n_cmp++; if (wr_addr.size() !== b + 3) begin n_fail++; $display("FAIL overrun_count: got %0d writes want 3", wr_addr.size() - b); end
    if (wr_addr.size() >= b + 3) begin
      n_cmp++; if (wr_addr[b+2] !== 32'h1010) begin n_fail++; $display("FAIL overrun_last_addr: got %h want 00001010", wr_addr[b+2]); end
      n_cmp++; if (wr_data[b+2] !== exp_data(1'b0, 2)) begin n_fail++; $display("FAIL overrun_last_data: got %h want %h", wr_data[b+2], exp_data(1'b0, 2)); end
    end
    n_cmp++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b want 1", err_overrun); end
    n_cmp++; if (frame_counter !== 32'd2) begin n_fail++; $display("FAIL overrun_frame_counter: got %0d want 2", frame_counter); end
    toggle_line();
    tick(20);
    n_cmp++; if (wr_addr.size() !== b + 3) begin n_fail++; $display("FAIL overrun_resync: got %0d writes want 3", wr_addr.size() - b); end
    n_cmp++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", err_overrun); end
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    n_cmp++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", err_overrun); end
    n_cmp++; if (nf_cnt - n0 !== 0) begin n_fail++; $display("FAIL overrun_new_frame: got %0d want 0", nf_cnt - n0); end
  endtask

  task automatic test_short();
    int b, n0;
    bit to;
    b = wr_addr.size(); n0 = nf_cnt;
    wait_n = 0; dma_base = 32'h3000;
    vblank_pulse();
    toggle_line();
    wait_writes(b + 4, 100, to);
    tick(3);
    n_cmp++; if (err_short !== 1'b0) begin n_fail++; $display("FAIL short_before: got %b want 0", err_short); end
    vblank_pulse();
    n_cmp++; if (err_short !== 1'b1) begin n_fail++; $display("FAIL short_flag: got %b want 1", err_short); end
    toggle_line();
    wait_writes(b + 8, 100, to);
    tick(3);
    n_cmp++; if (frame_counter !== 32'd2) begin n_fail++; $display("FAIL short_no_count: got %0d want 2", frame_counter); end
    toggle_line();
    wait_writes(b + 12, 100, to);
    tick(5);
    n_cmp++; if (wr_addr.size() !== b + 12) begin n_fail++; $display("FAIL short_count: got %0d writes want 12", wr_addr.size() - b); end
    if (wr_addr.size() >= b + 12) begin
      n_cmp++; if (wr_addr[b+4] !== 32'h3000) begin n_fail++; $display("FAIL short_restart_addr: got %h want 00003000", wr_addr[b+4]); end
      n_cmp++; if (wr_data[b+4] !== exp_data(1'b0, 0)) begin n_fail++; $display("FAIL short_restart_data: got %h want %h", wr_data[b+4], exp_data(1'b0, 0)); end
      n_cmp++; if (wr_addr[b+11] !== 32'h3038) begin n_fail++; $display("FAIL short_last_addr: got %h want 00003038", wr_addr[b+11]); end
    end
    n_cmp++; if (frame_counter !== 32'd3) begin n_fail++; $display("FAIL short_frame_counter: got %0d want 3", frame_counter); end
    n_cmp++; if (nf_cnt - n0 !== 1) begin n_fail++; $display("FAIL short_new_frame: got %0d want 1", nf_cnt - n0); end
  endtask

  task automatic test_disable();
    int b, c;
    b = wr_addr.size();
    wait_n = 3; dma_base = 32'h4000;
    vblank_pulse();
    toggle_line();
    c = 0;
    while (!(bus.m_write && bus.m_waitrequest) && c < 50) begin tick(1); c++; end
    n_cmp++; if (c >= 50) begin n_fail++; $display("FAIL disable_stall_timeout: got %0d cycles want <50", c); end
    dma_enable = 1'b0;
    c = 0;
    while (!(bus.m_write && !bus.m_waitrequest) && c < 50) begin tick(1); c++; end
    n_cmp++; if (dma_active !== 1'b1) begin n_fail++; $display("FAIL disable_active_during: got %b want 1", dma_active); end
    tick(1);
    n_cmp++; if (dma_active !== 1'b0) begin n_fail++; $display("FAIL disable_active_after: got %b want 0", dma_active); end
    n_cmp++; if (wr_addr.size() !== b + 1) begin n_fail++; $display("FAIL disable_count: got %0d writes want 1", wr_addr.size() - b); end
    if (wr_addr.size() >= b + 1) begin
      n_cmp++; if (wr_addr[b] !== 32'h4000) begin n_fail++; $display("FAIL disable_addr: got %h want 00004000", wr_addr[b]); end
    end
    tick(20);
    n_cmp++; if (wr_addr.size() !== b + 1 || bus.m_write !== 1'b0) begin n_fail++; $display("FAIL disable_quiet: got %0d writes m_write=%b want 1 and 0", wr_addr.size() - b, bus.m_write); end
  endtask

  task automatic test_async_reset();
    int c;
    wait_n = 3; dma_base = 32'h5000; dma_enable = 1'b1;
    tick(3);
    vblank_pulse();
    toggle_line();
    c = 0;
    while (!bus.m_write && c < 50) begin tick(1); c++; end
    n_cmp++; if (bus.m_address !== 32'h5000) begin n_fail++; $display("FAIL areset_pre_addr: got %h want 00005000", bus.m_address); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.m_write, bus.vm_bus_enable, dma_active, new_frame} !== 4'b0000) begin n_fail++; $display("FAIL areset_ctrl: got %b want 0000", {bus.m_write, bus.vm_bus_enable, dma_active, new_frame}); end
    n_cmp++; if (bus.m_address !== 32'h0 || bus.m_writedata !== 64'h0 || bus.vm_address !== 10'h0) begin n_fail++; $display("FAIL areset_bus: got %h %h %h want zeros", bus.m_address, bus.m_writedata, bus.vm_address); end
    n_cmp++; if (frame_counter !== 32'd0) begin n_fail++; $display("FAIL areset_frame_counter: got %0d want 0", frame_counter); end
    n_cmp++; if ({err_overrun, err_short} !== 2'b00) begin n_fail++; $display("FAIL areset_errors: got %b want 00", {err_overrun, err_short}); end
    n_cmp++; if (bus.vm_rw !== 1'b1) begin n_fail++; $display("FAIL areset_vm_rw: got %b want 1", bus.vm_rw); end
    dma_enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    n_cmp++; if (dma_active !== 1'b0 || bus.m_write !== 1'b0) begin n_fail++; $display("FAIL areset_after: got active=%b m_write=%b want 0 0", dma_active, bus.m_write); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_overrun();
    test_short();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
